// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//
// Shares one Avalon-MM SDRAM master between N_REQ requesters of the
// rasterizer unit: vertex fetch (port 0), depth/color fetch (port 1) and
// z-test writeback (port 2). Transfers are arbitrated round-robin, one
// transfer per grant. A granted transfer that the controller stalls keeps
// the grant until it is accepted. Pipelined reads are tracked in an
// owner-tag FIFO so that each returning read word is steered back to the
// port that issued it. Requests and responses pass through combinationally,
// so the arbiter adds no latency in either direction.
//
// Ports
//   clock, reset           system clock, asynchronous active-high reset
//   req_address            per-port word address (slice i = port i)
//   req_read, req_write    per-port transfer requests
//   req_byteenable         per-port byte enables
//   req_writedata          per-port write data
//   req_waitrequest        per-port stall back to the requester
//   req_readdata           read data, broadcast to every port
//   req_readdatavalid      per-port read-data strobe
//   master_*               Avalon-MM master towards the SDRAM controller
//   outstanding            number of reads issued but not yet returned
//   rd_underflow           sticky: read data arrived with no read outstanding

module sdram_port_arbiter #(
    parameter int N_REQ     = 3,
    parameter int ADDR_W    = 26,
    parameter int TAG_DEPTH = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_REQ*ADDR_W-1:0]       req_address,
    input  logic [N_REQ-1:0]              req_read,
    input  logic [N_REQ-1:0]              req_write,
    input  logic [N_REQ*4-1:0]            req_byteenable,
    input  logic [N_REQ*32-1:0]           req_writedata,
    output logic [N_REQ-1:0]              req_waitrequest,
    output logic [31:0]                   req_readdata,
    output logic [N_REQ-1:0]              req_readdatavalid,
    output logic [ADDR_W-1:0]             master_address,
    output logic                          master_read,
    output logic                          master_write,
    output logic [3:0]                    master_byteenable,
    output logic [31:0]                   master_writedata,
    input  logic [31:0]                   master_readdata,
    input  logic                          master_readdatavalid,
    input  logic                          master_waitrequest,
    output logic [$clog2(TAG_DEPTH):0]    outstanding,
    output logic                          rd_underflow
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FREE: the grant follows the round-robin search.
    // LOCKED: a stalled transfer owns the bus until the controller takes it.
    typedef enum logic {
        ARB_FREE,
        ARB_LOCKED
    } arb_state_t;

    arb_state_t        state;
    arb_state_t        state_next;
    logic [ID_W-1:0]   lock_id;
    logic [ID_W-1:0]   lock_id_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_ptr_next;

    logic [ID_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              room;
    logic [N_REQ-1:0]  eligible;
    logic              grant_valid;
    logic [ID_W-1:0]   grant;
    logic              sel_read;
    logic              sel_write;
    logic              accept;

    assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count == '0);

    // A response retires the head tag in the same cycle, which frees a slot
    // for a read being accepted in that very cycle.
    assign pop  = master_readdatavalid && !fifo_empty && !reset;
    assign room = !fifo_full || pop;

    // A read may only be presented when its owner tag can be stored, so a
    // read facing a full FIFO simply waits while writes keep flowing.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req_write[i] || (req_read[i] && room);
        end
    end

    // Grant selection. A locked grant is honoured while its owner still
    // requests; otherwise the search starts at rr_ptr and wraps around.
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_id;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        idx_id      = '0;
        if (state == ARB_LOCKED && eligible[lock_id]) begin
            grant_valid = 1'b1;
            grant       = lock_id;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                idx_id = ID_W'(idx);
                if (!grant_valid && eligible[idx_id]) begin
                    grant_valid = 1'b1;
                    grant       = idx_id;
                end
            end
        end
    end

    // Master side: the granted port drives the bus directly. A port that
    // raises read and write together has its read dropped.
    always_comb begin
        sel_read          = req_read[grant] && !req_write[grant];
        sel_write         = req_write[grant];
        master_address    = req_address[int'(grant)*ADDR_W +: ADDR_W];
        master_byteenable = req_byteenable[int'(grant)*4 +: 4];
        master_writedata  = req_writedata[int'(grant)*32 +: 32];
        master_read       = !reset && grant_valid && sel_read;
        master_write      = !reset && grant_valid && sel_write;
    end

    assign accept = grant_valid && (master_read || master_write) && !master_waitrequest;
    assign push   = accept && master_read;

    // Requester side: only the granted port may proceed, and only when the
    // controller is not stalling. Read strobes go to the owner at the head.
    always_comb begin
        req_waitrequest   = '1;
        req_readdatavalid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_waitrequest[i]   = reset || !(grant_valid && grant == ID_W'(i))
                                   || master_waitrequest;
            req_readdatavalid[i] = pop && (tag_mem[rd_ptr] == ID_W'(i));
        end
    end

    assign req_readdata = master_readdata;
    assign outstanding  = count;

    // Arbiter next state. An accepted transfer moves the round-robin pointer
    // past the winner and releases any lock; a stalled one pins the grant.
    always_comb begin
        state_next   = state;
        lock_id_next = lock_id;
        rr_ptr_next  = rr_ptr;
        if (accept) begin
            state_next  = ARB_FREE;
            rr_ptr_next = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + ID_W'(1);
        end else if (grant_valid && master_waitrequest) begin
            state_next   = ARB_LOCKED;
            lock_id_next = grant;
        end else if (!grant_valid) begin
            state_next = ARB_FREE;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ARB_FREE;
            lock_id <= '0;
            rr_ptr  <= '0;
        end else begin
            state   <= state_next;
            lock_id <= lock_id_next;
            rr_ptr  <= rr_ptr_next;
        end
    end

    // Tag storage carries no reset; validity is defined by the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

    // FIFO pointers, occupancy and the sticky underflow flag. Pointers wrap
    // naturally because the depth is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (master_readdatavalid && fifo_empty) begin
                rd_underflow <= 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // A requester must never ask for a read and a write at the same time.
    read_write_exclusive: assert property (
        @(posedge clock) disable iff (reset) ((req_read & req_write) == '0)
    );
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//
// Table-driven directed vectors for the multi-port scenarios, a hand-written
// reset-with-reads-in-flight sequence, and a randomized run checked against a
// queue-based reference model of the arbiter.

module tb_sdram_port_arbiter;

    localparam int N     = 3;
    localparam int AW    = 26;
    localparam int DEPTH = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N*AW-1:0]   req_address = '0;
    logic [N-1:0]      req_read = '0;
    logic [N-1:0]      req_write = '0;
    logic [N*4-1:0]    req_byteenable = '0;
    logic [N*32-1:0]   req_writedata = '0;
    logic [N-1:0]      req_waitrequest;
    logic [31:0]       req_readdata;
    logic [N-1:0]      req_readdatavalid;
    logic [AW-1:0]     master_address;
    logic              master_read;
    logic              master_write;
    logic [3:0]        master_byteenable;
    logic [31:0]       master_writedata;
    logic [31:0]       master_readdata = '0;
    logic              master_readdatavalid = 1'b0;
    logic              master_waitrequest = 1'b0;
    logic [3:0]        outstanding;
    logic              rd_underflow;

    sdram_port_arbiter #(
        .N_REQ     (N),
        .ADDR_W    (AW),
        .TAG_DEPTH (DEPTH)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .req_address          (req_address),
        .req_read             (req_read),
        .req_write            (req_write),
        .req_byteenable       (req_byteenable),
        .req_writedata        (req_writedata),
        .req_waitrequest      (req_waitrequest),
        .req_readdata         (req_readdata),
        .req_readdatavalid    (req_readdatavalid),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_byteenable    (master_byteenable),
        .master_writedata     (master_writedata),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_waitrequest   (master_waitrequest),
        .outstanding          (outstanding),
        .rd_underflow         (rd_underflow)
    );

    always #5 clock = ~clock;

    // Per-port transfer attributes and the currently driven control inputs.
    logic [AW-1:0] p_addr [N];
    logic [31:0]   p_data [N];
    logic [3:0]    p_be   [N];
    logic [N-1:0]  cur_rd;
    logic [N-1:0]  cur_wr;
    logic          cur_mwait;
    logic [31:0]   cur_rdata;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        bit          rst;
        logic [2:0]  rd;
        logic [2:0]  wr;
        logic        mwait;
        logic        mrdv;
        int          g;
        logic [2:0]  rdv;
        int          outs;
        logic        uf;
    } vec_t;

    vec_t vecs[$];

    // Reference model state.
    int   m_rr;
    int   m_lock;
    int   m_q[$];
    logic m_uf;
    int   p_op [N];

    task automatic addRow(input bit rst, input logic [2:0] rd, input logic [2:0] wr,
                          input logic mwait, input logic mrdv, input int g,
                          input logic [2:0] rdv, input int outs, input logic uf);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.mwait = mwait; v.mrdv = mrdv;
        v.g = g; v.rdv = rdv; v.outs = outs; v.uf = uf;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [2:0] rd, input logic [2:0] wr,
                                 input logic mwait, input logic mrdv);
        cur_rd    = rd;
        cur_wr    = wr;
        cur_mwait = mwait;
        cur_rdata = $urandom;
        for (int i = 0; i < N; i++) begin
            req_address[i*AW +: AW]  = p_addr[i];
            req_writedata[i*32 +: 32] = p_data[i];
            req_byteenable[i*4 +: 4] = p_be[i];
        end
        req_read             = rd;
        req_write            = wr;
        master_waitrequest   = mwait;
        master_readdatavalid = mrdv;
        master_readdata      = cur_rdata;
    endtask

    task automatic compare(input string name, input int row,
                           input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s row %0d: got %0h expected %0h", name, row, got, exp);
        end
    endtask

    // Expected bus values follow from the granted port and the driven inputs.
    task automatic checkOutput(input int row, input int g, input logic [2:0] e_rdv,
                               input int e_outs, input logic e_uf);
        logic       e_mr;
        logic       e_mw;
        logic [2:0] e_wait;
        e_mr = 1'b0;
        e_mw = 1'b0;
        if (g >= 0) begin
            e_mr = cur_rd[g] && !cur_wr[g];
            e_mw = cur_wr[g];
        end
        for (int i = 0; i < N; i++) begin
            e_wait[i] = (g != i) || cur_mwait;
        end
        compare("master_read", row, 64'(master_read), 64'(e_mr));
        compare("master_write", row, 64'(master_write), 64'(e_mw));
        if (g >= 0 && (e_mr || e_mw)) begin
            compare("master_address", row, 64'(master_address), 64'(p_addr[g]));
            compare("master_byteenable", row, 64'(master_byteenable), 64'(p_be[g]));
            if (e_mw) begin
                compare("master_writedata", row, 64'(master_writedata), 64'(p_data[g]));
            end
        end
        compare("req_waitrequest", row, 64'(req_waitrequest), 64'(e_wait));
        compare("req_readdatavalid", row, 64'(req_readdatavalid), 64'(e_rdv));
        compare("req_readdata", row, 64'(req_readdata), 64'(cur_rdata));
        compare("outstanding", row, 64'(outstanding), 64'(e_outs));
        compare("rd_underflow", row, 64'(rd_underflow), 64'(e_uf));
    endtask

    // Holds reset for a cycle with requests and a response pending to show
    // that everything is gated, then releases it on a falling edge.
    task automatic applyReset();
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(3'b111, 3'b000, 1'b0, 1'b1);
        #1;
        compare("reset master_read", -1, 64'(master_read), 64'(0));
        compare("reset master_write", -1, 64'(master_write), 64'(0));
        compare("reset waitrequest", -1, 64'(req_waitrequest), 64'(3'b111));
        compare("reset readdatavalid", -1, 64'(req_readdatavalid), 64'(0));
        compare("reset outstanding", -1, 64'(outstanding), 64'(0));
        compare("reset rd_underflow", -1, 64'(rd_underflow), 64'(0));
        @(negedge clock);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        p_addr[0] = 26'h00000A0; p_data[0] = 32'h11111111; p_be[0] = 4'hA;
        p_addr[1] = 26'h00000B0; p_data[1] = 32'h22222222; p_be[1] = 4'h5;
        p_addr[2] = 26'h0000100; p_data[2] = 32'hDEADBEEF; p_be[2] = 4'hF;
        cur_rd = '0; cur_wr = '0; cur_mwait = 1'b0; cur_rdata = '0;

        // Single write from port 2, then all ports write: rr_ptr is back at 0.
        addRow(1, 3'b000, 3'b100, 0, 0,  2, 3'b000, 0, 0);
        addRow(0, 3'b000, 3'b111, 1, 0,  0, 3'b000, 0, 0);
        addRow(0, 3'b000, 3'b111, 0, 0,  0, 3'b000, 0, 0);
        addRow(0, 3'b000, 3'b000, 0, 0, -1, 3'b000, 0, 0);
        // Continuous reads on all ports, responses three cycles later.
        addRow(1, 3'b111, 3'b000, 0, 0,  0, 3'b000, 0, 0);
        addRow(0, 3'b111, 3'b000, 0, 0,  1, 3'b000, 1, 0);
        addRow(0, 3'b111, 3'b000, 0, 0,  2, 3'b000, 2, 0);
        addRow(0, 3'b111, 3'b000, 0, 1,  0, 3'b001, 3, 0);
        addRow(0, 3'b111, 3'b000, 0, 1,  1, 3'b010, 3, 0);
        addRow(0, 3'b111, 3'b000, 0, 1,  2, 3'b100, 3, 0);
        addRow(0, 3'b000, 3'b000, 0, 1, -1, 3'b001, 3, 0);
        addRow(0, 3'b000, 3'b000, 0, 1, -1, 3'b010, 2, 0);
        addRow(0, 3'b000, 3'b000, 0, 1, -1, 3'b100, 1, 0);
        addRow(0, 3'b000, 3'b000, 0, 0, -1, 3'b000, 0, 0);
        // Port 1 stalled four cycles while port 0 becomes eligible.
        addRow(1, 3'b010, 3'b000, 1, 0,  1, 3'b000, 0, 0);
        addRow(0, 3'b011, 3'b000, 1, 0,  1, 3'b000, 0, 0);
        addRow(0, 3'b011, 3'b000, 1, 0,  1, 3'b000, 0, 0);
        addRow(0, 3'b011, 3'b000, 1, 0,  1, 3'b000, 0, 0);
        addRow(0, 3'b011, 3'b000, 0, 0,  1, 3'b000, 0, 0);
        addRow(0, 3'b011, 3'b000, 0, 0,  0, 3'b000, 1, 0);
        addRow(0, 3'b000, 3'b000, 0, 1, -1, 3'b010, 2, 0);
        addRow(0, 3'b000, 3'b000, 0, 1, -1, 3'b001, 1, 0);
        addRow(0, 3'b000, 3'b000, 0, 0, -1, 3'b000, 0, 0);
        // Fill the tag FIFO, write bypasses the blocked reads, then push+pop.
        addRow(1, 3'b011, 3'b000, 0, 0,  0, 3'b000, 0, 0);
        addRow(0, 3'b011, 3'b000, 0, 0,  1, 3'b000, 1, 0);
        addRow(0, 3'b011, 3'b000, 0, 0,  0, 3'b000, 2, 0);
        addRow(0, 3'b011, 3'b000, 0, 0,  1, 3'b000, 3, 0);
        addRow(0, 3'b011, 3'b000, 0, 0,  0, 3'b000, 4, 0);
        addRow(0, 3'b011, 3'b000, 0, 0,  1, 3'b000, 5, 0);
        addRow(0, 3'b011, 3'b000, 0, 0,  0, 3'b000, 6, 0);
        addRow(0, 3'b011, 3'b000, 0, 0,  1, 3'b000, 7, 0);
        addRow(0, 3'b011, 3'b100, 0, 0,  2, 3'b000, 8, 0);
        addRow(0, 3'b011, 3'b000, 0, 1,  0, 3'b001, 8, 0);
        addRow(0, 3'b011, 3'b000, 0, 1,  1, 3'b010, 8, 0);
        addRow(0, 3'b000, 3'b000, 0, 0, -1, 3'b000, 8, 0);
        addRow(0, 3'b011, 3'b000, 0, 0, -1, 3'b000, 8, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                applyReset();
            end
            @(negedge clock);
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].mwait, vecs[i].mrdv);
            #1;
            checkOutput(i, vecs[i].g, vecs[i].rdv, vecs[i].outs, vecs[i].uf);
        end

        // Reset with three reads in flight; their late responses underflow.
        applyReset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            applyStimulus(3'b111, 3'b000, 1'b0, 1'b0);
            #1;
            checkOutput(100 + k, k, 3'b000, k, 1'b0);
        end
        @(negedge clock);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        #1;
        checkOutput(103, -1, 3'b000, 3, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        compare("async reset outstanding", 104, 64'(outstanding), 64'(0));
        compare("async reset waitrequest", 104, 64'(req_waitrequest), 64'(3'b111));
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);
            #1;
            checkOutput(110 + k, -1, 3'b000, 0, (k > 0));
        end
        @(negedge clock);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        #1;
        checkOutput(113, -1, 3'b000, 0, 1'b1);

        // Randomized traffic against the reference model. Each port holds a
        // request until it is accepted, as an Avalon master must.
        applyReset();
        m_rr   = 0;
        m_lock = -1;
        m_q.delete();
        m_uf   = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_op[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [2:0] rd;
            logic [2:0] wr;
            logic       mwait;
            logic       mrdv;
            logic       pop;
            logic       room;
            logic [2:0] e_rdv;
            int         g;
            int         idx;
            int         size_before;
            @(negedge clock);
            rd = '0;
            wr = '0;
            for (int i = 0; i < N; i++) begin
                if (p_op[i] == 0 && $urandom_range(0, 99) < 40) begin
                    p_op[i]   = $urandom_range(1, 2);
                    p_addr[i] = AW'($urandom);
                    p_data[i] = $urandom;
                    p_be[i]   = 4'($urandom);
                end
                rd[i] = (p_op[i] == 1);
                wr[i] = (p_op[i] == 2);
            end
            mwait = ($urandom_range(0, 99) < 25);
            if (m_q.size() > 0) begin
                mrdv = ($urandom_range(0, 99) < 45);
            end else begin
                mrdv = ($urandom_range(0, 199) == 0);
            end
            applyStimulus(rd, wr, mwait, mrdv);

            size_before = m_q.size();
            pop  = mrdv && (size_before > 0);
            room = (size_before < DEPTH) || pop;
            g = m_lock;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && (wr[idx] || (rd[idx] && room))) begin
                    g = idx;
                end
            end
            e_rdv = pop ? 3'(1 << m_q[0]) : 3'b000;
            #1;
            checkOutput(1000 + cyc, g, e_rdv, size_before, m_uf);

            if (pop) begin
                void'(m_q.pop_front());
            end
            if (mrdv && size_before == 0) begin
                m_uf = 1'b1;
            end
            if (g >= 0 && !mwait) begin
                if (rd[g] && !wr[g]) begin
                    m_q.push_back(g);
                end
                m_rr    = (g + 1) % N;
                m_lock  = -1;
                p_op[g] = 0;
            end else if (g >= 0) begin
                m_lock = g;
            end
        end

        @(negedge clock);
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
